// File: rtl/vram_pkg.sv
// vram_pkg
// Shared types and constants for the VRAM arbiter slice.
//   rd_tag_t  : identifies which requester owns a read as it moves through
//               the VRAM read latency (NONE is used for writes and idle).
//   mem_cmd_t : one VRAM command at the package default widths, so that
//               integrators and benches can pass whole commands around.
//   VRAM_ADDR_W / VRAM_DATA_W : default widths used by vram_arbiter.
package vram_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 32;
  localparam int VRAM_BE_W   = VRAM_DATA_W / 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } rd_tag_t;

  typedef struct packed {
    logic                   en;
    logic                   we;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] wdata;
    logic [VRAM_BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe
// Fixed-depth shift register of read tags. A tag enters when a command is
// granted and leaves DEPTH cycles later, which the arbiter sizes so that the
// exiting tag lines up with the VRAM read data of that same command.
// Ports:
//   i_clk   : system clock
//   i_clear : synchronous clear, empties every stage to TAG_NONE
//   i_tag   : tag of the command granted this cycle (TAG_NONE if none)
//   o_tag   : tag whose read data is on the VRAM data bus this cycle
module rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    i_clk,
  input  logic    i_clear,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  // Shift one stage per cycle; clearing drops every in-flight read.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= TAG_NONE;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares a single-port VRAM between the VGA pixel-fetch engine (read-only,
// deadline-critical) and the game-logic/CPU bridge (read/write). Video has
// fixed priority, except that a CPU request which has waited STARVE_MAX
// consecutive cycles is granted over video. Accepted commands are registered
// onto the mem_* bus one cycle after the grant, and read data is steered back
// to its owner by a tag pipeline matched to the VRAM read latency.
// Ports:
//   i_clk, i_reset                : clock, synchronous active-high reset
//   i_vid_req/i_vid_addr          : video read request, held until o_vid_gnt
//   o_vid_gnt                     : video request accepted this cycle
//   o_vid_rvalid/o_vid_rdata      : video read return (one-cycle pulse)
//   o_vid_miss                    : video request denied by starvation override
//   i_cpu_req/we/addr/wdata/be    : CPU request, held until o_cpu_gnt
//   o_cpu_gnt                     : CPU request accepted this cycle
//   o_cpu_rvalid/o_cpu_rdata      : CPU read return (never for writes)
//   o_mem_en/we/addr/wdata/be     : registered VRAM command
//   i_mem_rdata                   : VRAM data, valid RD_LAT cycles after a read
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_vid_req,
  input  logic [ADDR_W-1:0]   i_vid_addr,
  output logic                o_vid_gnt,
  output logic                o_vid_rvalid,
  output logic [DATA_W-1:0]   o_vid_rdata,
  output logic                o_vid_miss,
  input  logic                i_cpu_req,
  input  logic                i_cpu_we,
  input  logic [ADDR_W-1:0]   i_cpu_addr,
  input  logic [DATA_W-1:0]   i_cpu_wdata,
  input  logic [DATA_W/8-1:0] i_cpu_be,
  output logic                o_cpu_gnt,
  output logic                o_cpu_rvalid,
  output logic [DATA_W-1:0]   o_cpu_rdata,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int            BE_W       = DATA_W / 8;
  localparam int            TAG_DEPTH  = RD_LAT + 1;
  localparam logic [7:0]    STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]        r_starve_cnt;
  logic              w_override;
  logic              w_vid_gnt;
  logic              w_cpu_gnt;
  logic              w_vid_miss;
  rd_tag_t           w_tag_in;
  rd_tag_t           w_tag_out;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;

  logic              r_vid_rvalid;
  logic [DATA_W-1:0] r_vid_rdata;
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;

  // Arbitration is purely combinational so a request can be accepted in the
  // same cycle it appears. The starvation override outranks video; nothing is
  // granted while reset is high.
  always_comb begin
    w_override = i_cpu_req && (r_starve_cnt == STARVE_LIM);
    w_vid_gnt  = 1'b0;
    w_cpu_gnt  = 1'b0;
    w_vid_miss = 1'b0;
    w_tag_in   = TAG_NONE;
    if (!i_reset) begin
      if (w_override) begin
        w_cpu_gnt  = 1'b1;
        w_vid_miss = i_vid_req;
      end else if (i_vid_req) begin
        w_vid_gnt = 1'b1;
      end else if (i_cpu_req) begin
        w_cpu_gnt = 1'b1;
      end
    end
    if (w_vid_gnt) begin
      w_tag_in = TAG_VID;
    end else if (w_cpu_gnt && !i_cpu_we) begin
      w_tag_in = TAG_CPU;
    end
  end

  // Counts consecutive cycles a CPU request has been left waiting. It stops
  // at STARVE_MAX, which is exactly the value that forces the override.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve_cnt <= 8'd0;
    end else if (!i_cpu_req || w_cpu_gnt) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt < STARVE_LIM) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // Command register: whatever was granted this cycle is driven to the VRAM
  // next cycle. Reads always use full byte enables; idle cycles drive zeros.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_mem_en    <= w_vid_gnt || w_cpu_gnt;
      r_mem_we    <= w_cpu_gnt && i_cpu_we;
      r_mem_addr  <= w_vid_gnt ? i_vid_addr : (w_cpu_gnt ? i_cpu_addr : '0);
      r_mem_wdata <= (w_cpu_gnt && i_cpu_we) ? i_cpu_wdata : '0;
      if (w_cpu_gnt && i_cpu_we) begin
        r_mem_be <= i_cpu_be;
      end else if (w_vid_gnt || w_cpu_gnt) begin
        r_mem_be <= '1;
      end else begin
        r_mem_be <= '0;
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  // Capture VRAM data for whichever requester the exiting tag names. Each
  // rdata register only loads on its own pulse, so it holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vid_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_vid_rdata  <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      r_vid_rvalid <= (w_tag_out == TAG_VID);
      r_cpu_rvalid <= (w_tag_out == TAG_CPU);
      if (w_tag_out == TAG_VID) begin
        r_vid_rdata <= i_mem_rdata;
      end
      if (w_tag_out == TAG_CPU) begin
        r_cpu_rdata <= i_mem_rdata;
      end
    end
  end

  // Registered outputs are forced low while reset is held so the VRAM and
  // both requesters see a quiet bus in the reset cycle itself.
  assign o_vid_gnt    = w_vid_gnt;
  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_vid_miss   = w_vid_miss;
  assign o_mem_en     = r_mem_en && !i_reset;
  assign o_mem_we     = r_mem_we && !i_reset;
  assign o_mem_addr   = i_reset ? '0 : r_mem_addr;
  assign o_mem_wdata  = i_reset ? '0 : r_mem_wdata;
  assign o_mem_be     = i_reset ? '0 : r_mem_be;
  assign o_vid_rvalid = r_vid_rvalid && !i_reset;
  assign o_cpu_rvalid = r_cpu_rvalid && !i_reset;
  assign o_vid_rdata  = i_reset ? '0 : r_vid_rdata;
  assign o_cpu_rdata  = i_reset ? '0 : r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Self-checking bench for vram_arbiter with default parameters. Contains a
// behavioural VRAM with a fixed read latency, and a reference model that
// tracks grants, the CPU wait count and an ordered list of pending reads
// with their due cycle and expected data.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW     = 14;
  localparam int DW     = 32;
  localparam int BW     = 4;
  localparam int LAT    = 2;
  localparam int SMAX   = 8;
  localparam int MDEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vidReq = 1'b0;
  logic [AW-1:0] vidAddr = '0;
  logic          cpuReq = 1'b0;
  logic          cpuWe = 1'b0;
  logic [AW-1:0] cpuAddr = '0;
  logic [DW-1:0] cpuWdata = '0;
  logic [BW-1:0] cpuBe = '0;

  logic          vidGnt, vidRvalid, vidMiss, cpuGnt, cpuRvalid;
  logic [DW-1:0] vidRdata, cpuRdata;
  logic          memEn, memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [BW-1:0] memBe;
  logic [DW-1:0] memRdata;

  int numChecks = 0;
  int numFails  = 0;
  int cyc       = 0;
  int vidRvSeen = 0;
  int cpuRvSeen = 0;

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_vid_req    (vidReq),
    .i_vid_addr   (vidAddr),
    .o_vid_gnt    (vidGnt),
    .o_vid_rvalid (vidRvalid),
    .o_vid_rdata  (vidRdata),
    .o_vid_miss   (vidMiss),
    .i_cpu_req    (cpuReq),
    .i_cpu_we     (cpuWe),
    .i_cpu_addr   (cpuAddr),
    .i_cpu_wdata  (cpuWdata),
    .i_cpu_be     (cpuBe),
    .o_cpu_gnt    (cpuGnt),
    .o_cpu_rvalid (cpuRvalid),
    .o_cpu_rdata  (cpuRdata),
    .o_mem_en     (memEn),
    .o_mem_we     (memWe),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .o_mem_be     (memBe),
    .i_mem_rdata  (memRdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] initVal(input int a);
    return 32'hC0DE0000 ^ (32'(a) * 32'h00009E37) ^ 32'(a);
  endfunction

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old,
                                               input logic [DW-1:0] wd,
                                               input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic vr,
                               input logic [AW-1:0] va, input logic cr,
                               input logic cw, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cd, input logic [BW-1:0] cb);
    @(posedge clk);
    #1;
    rst = r; vidReq = vr; vidAddr = va;
    cpuReq = cr; cpuWe = cw; cpuAddr = ca; cpuWdata = cd; cpuBe = cb;
  endtask

  // Behavioural VRAM: byte-enabled writes, reads delivered LAT cycles after
  // the cycle in which the read strobe is seen. Non-read slots carry junk.
  logic [DW-1:0] vram [MDEPTH];
  logic [DW-1:0] rdPipe [LAT];
  logic [DW-1:0] wrTmp;
  assign memRdata = rdPipe[LAT-1];

  always @(posedge clk) begin
    rdPipe[0] <= (memEn && !memWe) ? vram[memAddr] : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    if (memEn && memWe) begin
      wrTmp = mergeBytes(vram[memAddr], memWdata, memBe);
      vram[memAddr] <= wrTmp;
    end
  end

  // Reference model, evaluated mid-cycle on every falling edge.
  typedef struct {
    int            due;
    bit            isVid;
    logic [DW-1:0] data;
  } rdItem_t;

  rdItem_t       pend [$];
  logic [DW-1:0] modelMem [MDEPTH];
  int            mStarve = 0;
  mem_cmd_t      expCmd = '0;
  logic [DW-1:0] lastVid = '0;
  logic [DW-1:0] lastCpu = '0;

  always @(negedge clk) begin
    logic eVv, eCv, eVg, eCg, eMiss;
    rdItem_t it;
    if (vidRvalid === 1'b1) vidRvSeen++;
    if (cpuRvalid === 1'b1) cpuRvSeen++;
    if (cyc > 0) begin
      if (rst) begin
        checkOutput("reset_outputs_zero",
                    64'({vidGnt, vidRvalid, vidMiss, cpuGnt, cpuRvalid, memEn,
                         memWe, memAddr, memBe, |vidRdata, |cpuRdata,
                         |memWdata}), 64'd0);
        pend.delete();
        mStarve = 0;
        expCmd  = '0;
        lastVid = '0;
        lastCpu = '0;
      end else begin
        eVv = 1'b0;
        eCv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          it = pend.pop_front();
          if (it.isVid) begin eVv = 1'b1; lastVid = it.data; end
          else          begin eCv = 1'b1; lastCpu = it.data; end
        end
        checkOutput("vid_rvalid", 64'(vidRvalid), 64'(eVv));
        checkOutput("cpu_rvalid", 64'(cpuRvalid), 64'(eCv));
        checkOutput("vid_rdata",  64'(vidRdata),  64'(lastVid));
        checkOutput("cpu_rdata",  64'(cpuRdata),  64'(lastCpu));

        checkOutput("mem_en", 64'(memEn), 64'(expCmd.en));
        if (expCmd.en) begin
          checkOutput("mem_we",   64'(memWe),   64'(expCmd.we));
          checkOutput("mem_addr", 64'(memAddr), 64'(expCmd.addr));
          checkOutput("mem_be",   64'(memBe),   64'(expCmd.be));
          if (expCmd.we) checkOutput("mem_wdata", 64'(memWdata), 64'(expCmd.wdata));
        end

        eVg = 1'b0; eCg = 1'b0; eMiss = 1'b0;
        if (cpuReq && mStarve == SMAX) begin eCg = 1'b1; eMiss = vidReq; end
        else if (vidReq)               eVg = 1'b1;
        else if (cpuReq)               eCg = 1'b1;
        checkOutput("vid_gnt",  64'(vidGnt),  64'(eVg));
        checkOutput("cpu_gnt",  64'(cpuGnt),  64'(eCg));
        checkOutput("vid_miss", 64'(vidMiss), 64'(eMiss));

        expCmd = '0;
        if (eVg) begin
          pend.push_back('{cyc + 2 + LAT, 1'b1, modelMem[vidAddr]});
          expCmd.en = 1'b1; expCmd.addr = vidAddr; expCmd.be = '1;
        end else if (eCg) begin
          expCmd.en = 1'b1; expCmd.addr = cpuAddr;
          if (cpuWe) begin
            modelMem[cpuAddr] = mergeBytes(modelMem[cpuAddr], cpuWdata, cpuBe);
            expCmd.we = 1'b1; expCmd.wdata = cpuWdata; expCmd.be = cpuBe;
          end else begin
            pend.push_back('{cyc + 2 + LAT, 1'b0, modelMem[cpuAddr]});
            expCmd.be = '1;
          end
        end
        if (!cpuReq || eCg) mStarve = 0;
        else if (mStarve < SMAX) mStarve = mStarve + 1;
      end
    end
  end

  typedef struct {
    logic vr;
    logic cr;
    logic cw;
    logic expVg;
    logic expCg;
    logic expMiss;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int vBase, cBase, found;
    logic [DW-1:0] gotData;
    logic vr, cr, cw, vGot, cGot;
    logic [AW-1:0] va, ca;
    logic [DW-1:0] cd;
    logic [BW-1:0] cb;

    for (int a = 0; a < MDEPTH; a++) begin
      vram[a]     = initVal(a);
      modelMem[a] = initVal(a);
    end
    for (int i = 0; i < LAT; i++) rdPipe[i] = '0;

    // Arbitration table, applied from a clean reset state.
    for (int i = 0; i < SMAX; i++) vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < SMAX; i++) vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});

    $display("[TB] reset and arbitration table");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);
    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].vr, 14'h020, vecs[i].cr, vecs[i].cw, 14'h040,
                    32'h11110000 + 32'(i), 4'b1111);
      @(negedge clk);
      checkOutput("tbl_vid_gnt",  64'(vidGnt),  64'(vecs[i].expVg));
      checkOutput("tbl_cpu_gnt",  64'(cpuGnt),  64'(vecs[i].expCg));
      checkOutput("tbl_vid_miss", 64'(vidMiss), 64'(vecs[i].expMiss));
    end
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);

    $display("[TB] video-only stream");
    vBase = vidRvSeen;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 14'(i), 0, 0, '0, '0, '0);
      @(negedge clk);
      checkOutput("stream_vid_gnt", 64'(vidGnt), 64'd1);
    end
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
    @(negedge clk);
    checkOutput("stream_rvalid_count", 64'(vidRvSeen - vBase), 64'd10);

    $display("[TB] cpu write then read");
    cBase = cpuRvSeen;
    applyStimulus(0, 0, '0, 1, 1, 14'h0123, 32'hDEADBEEF, 4'b0011);
    @(negedge clk);
    checkOutput("wr_cpu_gnt", 64'(cpuGnt), 64'd1);
    applyStimulus(0, 0, '0, 1, 0, 14'h0123, '0, '0);
    @(negedge clk);
    checkOutput("rd_cpu_gnt", 64'(cpuGnt), 64'd1);
    checkOutput("wr_mem_we", 64'(memWe), 64'd1);
    checkOutput("wr_mem_be", 64'(memBe), 64'b0011);
    found = 0;
    gotData = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
      @(negedge clk);
      if (cpuRvalid === 1'b1) begin found++; gotData = cpuRdata; end
    end
    checkOutput("rd_rvalid_once", 64'(found), 64'd1);
    checkOutput("rd_data", 64'(gotData),
                64'((initVal('h123) & 32'hFFFF0000) | 32'h0000BEEF));
    checkOutput("rd_cpu_rvalid_count", 64'(cpuRvSeen - cBase), 64'd1);

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 14'h030 + 14'(i), 0, 0, '0, '0, '0);
      @(negedge clk);
      checkOutput("mid_vid_gnt", 64'(vidGnt), 64'd1);
    end
    applyStimulus(1, 1, 14'h033, 1, 0, 14'h050, '0, '0);
    @(negedge clk);
    checkOutput("rst_no_gnt", 64'({vidGnt, cpuGnt}), 64'd0);
    vBase = vidRvSeen;
    cBase = cpuRvSeen;
    applyStimulus(0, 1, 14'h033, 1, 0, 14'h050, '0, '0);
    @(negedge clk);
    checkOutput("post_rst_vid_gnt", 64'(vidGnt), 64'd1);
    applyStimulus(0, 0, '0, 1, 0, 14'h050, '0, '0);
    @(negedge clk);
    checkOutput("post_rst_cpu_gnt", 64'(cpuGnt), 64'd1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
    @(negedge clk);
    checkOutput("post_rst_vid_rv", 64'(vidRvSeen - vBase), 64'd1);
    checkOutput("post_rst_cpu_rv", 64'(cpuRvSeen - cBase), 64'd1);

    $display("[TB] randomized traffic");
    vr = 0; cr = 0; cw = 0; va = '0; ca = '0; cd = '0; cb = '0;
    vGot = 0; cGot = 0;
    for (int n = 0; n < 400; n++) begin
      if (!vr || vGot) begin
        vr = ($urandom_range(0, 9) < ((n < 200) ? 7 : 10));
        va = 14'($urandom_range(0, 15));
      end
      if (!cr || cGot) begin
        cr = 1'($urandom_range(0, 1));
        cw = 1'($urandom_range(0, 1));
        ca = 14'($urandom_range(0, 15));
        cd = $urandom;
        cb = 4'($urandom_range(0, 15));
      end
      applyStimulus(0, vr, va, cr, cw, ca, cd, cb);
      @(negedge clk);
      vGot = vidGnt;
      cGot = cpuGnt;
    end
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
    @(negedge clk);
    checkOutput("drain_pending_empty", 64'(pend.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port on-chip video RAM between two requesters.
  - The VGA pixel-fetch engine (read-only, deadline-critical).
  - The game-logic / CPU-bridge port (read/write).
- Fixed priority to video, with a starvation guard so game-logic writes always progress.
- Routes pipelined read data back to the correct requester using a read-tag shift pipeline.
- Sits between the sprite/background renderer and the VRAM macro, alongside the SoC's keycode/hex/LED PIO glue.

Parameters:
- ADDR_W, 14, VRAM word address width.
- DATA_W, 32, VRAM data width; must be a multiple of 8.
- RD_LAT, 2, VRAM read latency in cycles from mem_en to mem_rdata valid; legal range 1..4.
- STARVE_MAX, 8, consecutive cycles the CPU may wait before it is granted over video; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vid_req  in  1  video read request; held with vid_addr until granted
- vid_addr  in  ADDR_W  video read address
- vid_gnt  out  1  video request accepted this cycle
- vid_rvalid  out  1  vid_rdata valid (one-cycle pulse)
- vid_rdata  out  DATA_W  video read data
- vid_miss  out  1  pulse: vid_req denied by the starvation override
- cpu_req  in  1  CPU request; held with all cpu_* inputs until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  write data
- cpu_be  in  DATA_W/8  write byte enables
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse); never pulsed for writes
- cpu_rdata  out  DATA_W  CPU read data
- mem_en  out  1  VRAM access strobe
- mem_we  out  1  VRAM write enable
- mem_addr  out  ADDR_W  VRAM address
- mem_wdata  out  DATA_W  VRAM write data
- mem_be  out  DATA_W/8  VRAM byte enables
- mem_rdata  in  DATA_W  VRAM read data, valid RD_LAT cycles after a read mem_en

Behaviour:
- Handshake: a transaction is accepted in any cycle where req && gnt. The requester drops or changes req only after gnt.
- Grants are combinational from req and the starvation state. At most one gnt per cycle.
- Arbitration, per cycle:
  - If cpu_req && starve_cnt == STARVE_MAX: cpu_gnt = 1, and vid_miss = vid_req.
  - Else if vid_req: vid_gnt = 1.
  - Else if cpu_req: cpu_gnt = 1.
- starve_cnt (8-bit):
  - Cleared on cpu_gnt or when !cpu_req.
  - Incremented when cpu_req && !cpu_gnt.
  - Saturates at STARVE_MAX.
- Command register: accepted command is registered onto mem_* at T+1 (grant cycle T).
  - mem_en = 1 only in cycles following a grant.
  - mem_we = 1 only for CPU writes.
  - mem_be = all ones for reads.
  - Back-to-back grants give one access per cycle; no bubbles.
- Read return:
  - A 2-bit tag (NONE/VID/CPU) enters an (RD_LAT+1)-deep shift pipeline at grant.
  - When the tag exits, mem_rdata is registered to the tagged requester's rdata, and its rvalid pulses at T+2+RD_LAT.
  - Reads return in acceptance order. Writes carry tag NONE.
- Throughput: one accepted transaction per cycle sustained. Video alone can be granted every cycle.
- Reset: all outputs 0. starve_cnt = 0. Tag pipeline cleared to NONE.
  - In-flight reads are discarded: no rvalid in any cycle after reset is sampled high.
  - Grants are inhibited during reset.
- Simultaneous vid_req and cpu_req with starve_cnt < STARVE_MAX: video wins, and starve_cnt increments.
- rdata holds its last value when rvalid = 0.

Decomposition:
- Package vram_pkg:
  - tag enum rd_tag_t {TAG_NONE, TAG_VID, TAG_CPU}
  - mem_cmd_t struct {en, we, addr, wdata, be}
  - default ADDR_W / DATA_W constants
- Sub-module rd_tag_pipe:
  - Parameterised depth shift register of rd_tag_t, with synchronous clear.
  - Outputs the tag aligned with mem_rdata.

Test Plan:
- Video-only stream: vid_req held 10 cycles, addr 0x000..0x009.
  - vid_gnt every cycle.
  - mem_addr 0x000..0x009 starting T+1.
  - vid_rvalid for 10 consecutive cycles starting T+4 (RD_LAT=2), data in order.
- CPU write then read, video idle: write 0xDEADBEEF to 0x0123 with be=4'b0011, then read 0x0123.
  - mem_we=1 with be=0011 on the first access.
  - cpu_rvalid exactly once, for the read only, with cpu_rdata = model value.
- Starvation: vid_req continuous, cpu_req raised at cycle 0, STARVE_MAX=8.
  - cpu_gnt at cycle 8 with vid_miss=1 that cycle.
  - vid_gnt resumes at cycle 9.
  - starve_cnt back to 0.
- Interleaved reads: alternating vid and cpu grants with distinct model data per address.
  - Every vid_rvalid/cpu_rvalid carries its own requester's data; no cross-routing.
- Reset mid-flight: three reads accepted, reset asserted the following cycle for 1 cycle.
  - No rvalid on any later cycle.
  - All outputs 0 during reset.
  - Normal grants resume the cycle after deassertion.
- Simultaneous first-cycle request: vid_req and cpu_req both rise together with starve_cnt=0.
  - vid_gnt=1, cpu_gnt=0.
  - starve_cnt=1 next cycle.
